// File: rtl/falcon_pkg.sv
// Shared Falcon keygen definitions: FSM state type, ring degree and the
// small-coefficient range limit derived from the keygen bit-width table.
package falcon_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // Bit width of f/g coefficients per logn, as used by keygen (logn=9 -> 6 bits, lim 31).
  function automatic int unsigned max_fg_bits(input int unsigned logn);
    case (logn)
      0, 1, 2, 3, 4, 5: return 8;
      6, 7:             return 7;
      8, 9:             return 6;
      default:          return 5;
    endcase
  endfunction

  function automatic int unsigned ring_n(input int unsigned logn);
    return 1 << logn;
  endfunction

  function automatic logic [31:0] coef_lim(input int unsigned logn);
    return (32'd1 << (max_fg_bits(logn) - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/poly_small_collect_if.sv
// Bundle between the keygen controller / Gaussian sampler / coefficient RAM
// and poly_small_collect. master = environment side, slave = collector side.
interface poly_small_collect_if #(
  parameter int unsigned logn = 9,
  parameter int unsigned CW   = 8
);
  logic                   start;
  logic                   odd_parity;
  logic                   abort;
  logic                   gauss_ena;
  logic                   val_valid;
  logic signed [31:0]     val;
  logic                   coef_we;
  logic [logn-1:0]        coef_addr;
  logic signed [CW-1:0]   coef_data;
  logic                   busy;
  logic                   done;
  logic [31:0]            sq_norm;

  modport master (
    output start, odd_parity, abort, val_valid, val,
    input  gauss_ena, coef_we, coef_addr, coef_data, busy, done, sq_norm
  );

  modport slave (
    input  start, odd_parity, abort, val_valid, val,
    output gauss_ena, coef_we, coef_addr, coef_data, busy, done, sq_norm
  );
endinterface

// File: rtl/gauss_coef_filter.sv
// Combinational accept/discard decision for one sampler value: range check
// against +/-lim plus the final-coefficient parity rule.
module gauss_coef_filter (
  input  logic signed [31:0] val,
  input  logic [31:0]        lim,
  input  logic               is_last,
  input  logic               odd_req,
  input  logic               parity,
  output logic               accept
);
  logic signed [31:0] lim_s;
  logic               in_range;
  logic               parity_ok;

  // Accept only in-range values; on the last slot also enforce the required parity.
  always_comb begin
    lim_s     = signed'(lim);
    in_range  = (val >= -lim_s) && (val <= lim_s);
    parity_ok = !(is_last && odd_req && ((parity ^ val[0]) == 1'b0));
    accept    = in_range && parity_ok;
  end
endmodule

// File: rtl/poly_small_collect.sv
// Collects 2^logn small Gaussian coefficients into the coefficient RAM,
// enforcing range and final parity, and reports the squared norm.
// Optional feature: NORM_ACC_EN enables the saturating sq_norm accumulator.
module poly_small_collect
  import falcon_pkg::*;
#(
  parameter int unsigned logn = 9,
  parameter int unsigned CW   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  poly_small_collect_if.slave  bus
);
  localparam logic [31:0] LIM = coef_lim(logn);

  state_t          state, state_nx;
  logic [logn-1:0] u;
  logic            parity;
  logic            odd_req;
  logic            accept;
  logic            is_last;
  logic            launch;
  logic            take;

  assign is_last = (u == '1);

  gauss_coef_filter u_filter (
    .val     (bus.val),
    .lim     (LIM),
    .is_last (is_last),
    .odd_req (odd_req),
    .parity  (parity),
    .accept  (accept)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state, launch/accept strobes and status outputs.
  always_comb begin
    state_nx      = state;
    launch        = 1'b0;
    take          = 1'b0;
    bus.busy      = 1'b0;
    bus.gauss_ena = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          launch   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        bus.busy      = 1'b1;
        bus.gauss_ena = 1'b1;
        if (bus.abort) begin
          state_nx = IDLE;
        end else if (bus.val_valid && accept) begin
          take = 1'b1;
          if (is_last) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Index, running parity and registered RAM write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u             <= '0;
      parity        <= 1'b0;
      odd_req       <= 1'b0;
      bus.coef_we   <= 1'b0;
      bus.coef_addr <= '0;
      bus.coef_data <= '0;
      bus.done      <= 1'b0;
    end else begin
      bus.coef_we <= 1'b0;
      bus.done    <= 1'b0;
      if (launch) begin
        u       <= '0;
        parity  <= 1'b0;
        odd_req <= bus.odd_parity;
      end
      if (take) begin
        bus.coef_we   <= 1'b1;
        bus.coef_addr <= u;
        bus.coef_data <= bus.val[CW-1:0];
        parity        <= parity ^ bus.val[0];
        bus.done      <= is_last;
        // u holds at N-1 after the final write; only start clears it.
        if (!is_last) u <= u + 1'b1;
      end
    end
  end

`ifdef NORM_ACC_EN
  logic signed [63:0] val_x;
  logic signed [63:0] sq;
  logic [32:0]        sum;
  logic [31:0]        norm_nx;
  logic [31:0]        norm_q;

  // Square of the incoming value added to the running norm, saturating at all-ones.
  always_comb begin
    val_x   = 64'(bus.val);
    sq      = val_x * val_x;
    sum     = {1'b0, norm_q} + {1'b0, sq[31:0]};
    norm_nx = ((sq[63:32] != '0) || sum[32]) ? '1 : sum[31:0];
  end

  // Norm accumulator: cleared on start, updated on accept, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      norm_q <= '0;
    else if (launch) norm_q <= '0;
    else if (take)   norm_q <= norm_nx;
  end

  assign bus.sq_norm = norm_q;
`else
  assign bus.sq_norm = '0;
`endif

endmodule
